// File: rtl/lut_pkg.sv
// Shared types and constants for the branch-target table loader and its storage.
package lut_pkg;

  // Loader sequence: header read, then a lo/hi byte pair per table entry
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RD_HDR,
    ST_WT_HDR,
    ST_RD_LO,
    ST_WT_LO,
    ST_RD_HI,
    ST_WT_HI,
    ST_DONE
  } lut_ld_state_t;

  localparam int LUT_PC_W    = 12;
  localparam int LUT_LABEL_W = 8;

  // Byte offsets inside the memory image: header, then {lo, hi} pairs
  localparam int unsigned HDR_OFS = 0;
  localparam int unsigned LO_OFS  = 1;
  localparam int unsigned HI_OFS  = 2;

  // Offset from the image base of one field of entry idx
  function automatic int unsigned field_offset(input int unsigned idx, input int unsigned ofs);
    return ofs + 2 * idx;
  endfunction

endpackage

// File: rtl/lut_regfile.sv
// Label -> next_pc storage with per-entry valid flags, one write port and a
// combinational read port. Unwritten or out-of-range labels read as zero.
module lut_regfile
  import lut_pkg::*;
#(
  parameter int NUM_LABELS = 64,
  parameter int PC_W       = LUT_PC_W,
  parameter int IDX_W      = (NUM_LABELS > 1) ? $clog2(NUM_LABELS) : 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   clear_all,
  input  logic                   we,
  input  logic [IDX_W-1:0]       widx,
  input  logic [PC_W-1:0]        wdata,
  input  logic [LUT_LABEL_W-1:0] rlabel,
  output logic [PC_W-1:0]        rdata
);

  localparam logic [LUT_LABEL_W:0] LABEL_LIM = NUM_LABELS[LUT_LABEL_W:0];

  logic [PC_W-1:0]       entries [NUM_LABELS];
  logic [NUM_LABELS-1:0] valid;
  logic                  in_range;
  logic [IDX_W-1:0]      ridx;

  // Valid flags are wiped by reset or a new load and set as each entry lands
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid <= '0;
    end else if (clear_all) begin
      valid <= '0;
    end else if (we) begin
      valid[widx] <= 1'b1;
    end
  end

  // Payload needs no reset because every read is gated by its valid flag
  always_ff @(posedge clk) begin
    if (we) begin
      entries[widx] <= wdata;
    end
  end

  // Combinational lookup, zero for labels beyond the table or not yet written
  always_comb begin
    in_range = ({1'b0, rlabel} < LABEL_LIM);
    ridx     = rlabel[IDX_W-1:0];
    rdata    = '0;
    if (in_range && valid[ridx]) begin
      rdata = entries[ridx];
    end
  end

endmodule

// File: rtl/lut_loader.sv
// Boot-time loader for the branch-target table: reads the entry count and
// {lo, hi} byte pairs from data memory, programs lut_regfile, and serves the
// combinational label lookup to fetch. done stays high until the next start.
module lut_loader
  import lut_pkg::*;
#(
  parameter int                NUM_LABELS = 64,
  parameter int                PC_W       = LUT_PC_W,
  parameter int                MEM_AW     = 8,
  parameter logic [MEM_AW-1:0] BASE_ADDR  = '0
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  output logic                   mem_rd_en,
  output logic [MEM_AW-1:0]      mem_addr,
  input  logic [7:0]             mem_rdata,
  output logic                   busy,
  output logic                   done,
  output logic                   error,
  input  logic [LUT_LABEL_W-1:0] label,
  output logic [PC_W-1:0]        next_pc
);

  localparam int               CNT_W   = $clog2(NUM_LABELS + 1);
  localparam int               IDX_W   = (NUM_LABELS > 1) ? $clog2(NUM_LABELS) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(NUM_LABELS);

  lut_ld_state_t     state, state_nxt;
  logic [CNT_W-1:0]  idx, cnt, hdr_cnt;
  logic [7:0]        lo_byte;
  logic [MEM_AW-1:0] addr_hold, hdr_addr, lo_addr, hi_addr;
  logic              hdr_over, hi_over, last_entry, load_go, we;
  logic [PC_W-1:0]   wdata;

  // A new load is only accepted when not already loading
  assign load_go = start && ((state == ST_IDLE) || (state == ST_DONE));

  // Header count is clamped to table capacity; an oversized header is a fault
  assign hdr_over = (32'(mem_rdata) > NUM_LABELS);
  assign hdr_cnt  = hdr_over ? CNT_MAX : CNT_W'(mem_rdata);

  // Any hi-byte bits above the next_pc width are a fault, but the entry is kept
  assign hi_over    = ((mem_rdata >> (PC_W - 8)) != 8'd0);
  assign last_entry = (CNT_W'(idx + 1'b1) == cnt);
  assign wdata      = PC_W'({mem_rdata, lo_byte});

  // Read addresses wrap modulo the memory size
  assign hdr_addr = MEM_AW'(32'(BASE_ADDR) + field_offset(32'(idx), HDR_OFS) - 2 * 32'(idx));
  assign lo_addr  = MEM_AW'(32'(BASE_ADDR) + field_offset(32'(idx), LO_OFS));
  assign hi_addr  = MEM_AW'(32'(BASE_ADDR) + field_offset(32'(idx), HI_OFS));

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE, ST_DONE: if (start) state_nxt = ST_RD_HDR;
      ST_RD_HDR:        state_nxt = ST_WT_HDR;
      ST_WT_HDR:        state_nxt = (hdr_cnt == '0) ? ST_DONE : ST_RD_LO;
      ST_RD_LO:         state_nxt = ST_WT_LO;
      ST_WT_LO:         state_nxt = ST_RD_HI;
      ST_RD_HI:         state_nxt = ST_WT_HI;
      ST_WT_HI:         state_nxt = last_entry ? ST_DONE : ST_RD_LO;
      default:          state_nxt = ST_IDLE;
    endcase
  end

  // Outputs decoded from the registered state; the address holds outside reads
  always_comb begin
    mem_rd_en = 1'b0;
    mem_addr  = addr_hold;
    we        = 1'b0;
    busy      = (state != ST_IDLE) && (state != ST_DONE);
    done      = (state == ST_DONE);
    case (state)
      ST_RD_HDR: begin
        mem_rd_en = 1'b1;
        mem_addr  = hdr_addr;
      end
      ST_RD_LO: begin
        mem_rd_en = 1'b1;
        mem_addr  = lo_addr;
      end
      ST_RD_HI: begin
        mem_rd_en = 1'b1;
        mem_addr  = hi_addr;
      end
      ST_WT_HI: we = 1'b1;
      default:  ;
    endcase
  end

  // Loader datapath: entry index, clamped count, lo byte, sticky fault, held address
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx       <= '0;
      cnt       <= '0;
      lo_byte   <= '0;
      error     <= 1'b0;
      addr_hold <= BASE_ADDR;
    end else begin
      addr_hold <= mem_addr;
      case (state)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            idx   <= '0;
            error <= 1'b0;
          end
        end
        ST_WT_HDR: begin
          cnt <= hdr_cnt;
          if (hdr_over) error <= 1'b1;
        end
        ST_WT_LO: lo_byte <= mem_rdata;
        ST_WT_HI: begin
          if (hi_over) error <= 1'b1;
          idx <= CNT_W'(idx + 1'b1);
        end
        default: ;
      endcase
    end
  end

  lut_regfile #(
    .NUM_LABELS (NUM_LABELS),
    .PC_W       (PC_W),
    .IDX_W      (IDX_W)
  ) u_regfile (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear_all (load_go),
    .we        (we),
    .widx      (idx[IDX_W-1:0]),
    .wdata     (wdata),
    .rlabel    (label),
    .rdata     (next_pc)
  );

endmodule

// File: tb/tb_lut_loader.sv
// Scoreboard bench for lut_loader: two instances (base 0x00 and base 0xFC),
// each with a 1-cycle-latency byte memory. Expected read addresses and lookup
// results are queued when a load is started and consumed as the DUT reads
// memory and after done rises.
`timescale 1ns/1ps
module tb_lut_loader;

  localparam int NL = 64;

  typedef struct {
    logic [7:0]  lbl;
    logic [11:0] pc;
  } lk_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start0, start1;
  logic        rd_en0, rd_en1;
  logic [7:0]  addr0, addr1, rdata0, rdata1;
  logic        busy0, busy1, done0, done1, err0, err1;
  logic [7:0]  label0, label1;
  logic [11:0] pc0, pc1;

  logic [7:0]  mem0 [256];
  logic [7:0]  mem1 [256];
  logic [15:0] tbl  [256];

  logic [7:0]  aq0 [$];
  logic [7:0]  aq1 [$];
  lk_t         lq0 [$];
  lk_t         lq1 [$];

  int num_checks = 0;
  int num_errors = 0;

  always #5 clk = ~clk;

  lut_loader #(.NUM_LABELS(NL), .PC_W(12), .MEM_AW(8), .BASE_ADDR(8'h00)) dut0 (
    .clk(clk), .rst_n(rst_n), .start(start0), .mem_rd_en(rd_en0), .mem_addr(addr0),
    .mem_rdata(rdata0), .busy(busy0), .done(done0), .error(err0), .label(label0), .next_pc(pc0)
  );

  lut_loader #(.NUM_LABELS(NL), .PC_W(12), .MEM_AW(8), .BASE_ADDR(8'hFC)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .mem_rd_en(rd_en1), .mem_addr(addr1),
    .mem_rdata(rdata1), .busy(busy1), .done(done1), .error(err1), .label(label1), .next_pc(pc1)
  );

  // Data memories answer one cycle after the read strobe
  always @(posedge clk) begin
    if (rd_en0) rdata0 <= mem0[addr0];
    if (rd_en1) rdata1 <= mem1[addr1];
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    num_checks++;
    if (obs !== exp) begin
      num_errors++;
      $display("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Every memory read must match the next queued address, in order
  always @(negedge clk) begin
    if (rd_en0) begin
      if (aq0.size() == 0) checkOutput("dut0 spurious rd_en", 32'(rd_en0), 32'd0);
      else                 checkOutput("dut0 rd_addr", 32'(addr0), 32'(aq0.pop_front()));
    end
    if (rd_en1) begin
      if (aq1.size() == 0) checkOutput("dut1 spurious rd_en", 32'(rd_en1), 32'd0);
      else                 checkOutput("dut1 rd_addr", 32'(addr1), 32'(aq1.pop_front()));
    end
  end

  function automatic logic done_of(input int inst);
    return (inst == 0) ? done0 : done1;
  endfunction

  function automatic logic busy_of(input int inst);
    return (inst == 0) ? busy0 : busy1;
  endfunction

  function automatic logic err_of(input int inst);
    return (inst == 0) ? err0 : err1;
  endfunction

  task automatic setStart(input int inst, input logic v);
    if (inst == 0) start0 = v;
    else           start1 = v;
  endtask

  task automatic writeMem(input int inst, input logic [7:0] a, input logic [7:0] d);
    if (inst == 0) mem0[a] = d;
    else           mem1[a] = d;
  endtask

  // Lay out the image from tbl[], queue expectations, then raise start
  task automatic applyStimulus(input int inst, input int n, output int eff, output logic exp_err);
    logic [7:0] base, a;
    lk_t        e;
    base    = (inst == 0) ? 8'h00 : 8'hFC;
    eff     = (n > NL) ? NL : n;
    exp_err = (n > NL);
    writeMem(inst, base, 8'(n));
    if (inst == 0) aq0.push_back(base); else aq1.push_back(base);
    for (int i = 0; i < eff; i++) begin
      a = 8'(base + 8'(1 + 2 * i));
      writeMem(inst, a, tbl[i][7:0]);
      if (inst == 0) aq0.push_back(a); else aq1.push_back(a);
      a = 8'(base + 8'(2 + 2 * i));
      writeMem(inst, a, tbl[i][15:8]);
      if (inst == 0) aq0.push_back(a); else aq1.push_back(a);
      if (tbl[i][15:12] != 4'h0) exp_err = 1'b1;
    end
    for (int l = 0; l < NL + 4; l++) begin
      e.lbl = (l < NL + 2) ? 8'(l) : ((l == NL + 2) ? 8'd128 : 8'd255);
      e.pc  = (int'(e.lbl) < eff) ? tbl[e.lbl][11:0] : 12'h000;
      if (inst == 0) lq0.push_back(e); else lq1.push_back(e);
    end
    @(negedge clk);
    setStart(inst, 1'b1);
  endtask

  // Drain the queued lookups against the combinational read port
  task automatic checkLookups(input int inst);
    lk_t e;
    while ((inst == 0) ? (lq0.size() != 0) : (lq1.size() != 0)) begin
      e = (inst == 0) ? lq0.pop_front() : lq1.pop_front();
      if (inst == 0) label0 = e.lbl; else label1 = e.lbl;
      #1;
      checkOutput($sformatf("dut%0d label %0d", inst, e.lbl),
                  32'((inst == 0) ? pc0 : pc1), 32'(e.pc));
    end
  endtask

  // Count cycles from the start cycle to done; optionally re-pulse start mid-load
  task automatic waitDone(input int inst, input int eff, input logic exp_err, input int poke_at);
    int cycles = 0;
    do begin
      @(posedge clk);
      #1;
      cycles++;
      if (cycles == 1) begin
        checkOutput($sformatf("dut%0d error cleared by start", inst), 32'(err_of(inst)), 32'd0);
        checkOutput($sformatf("dut%0d busy after start", inst), 32'(busy_of(inst)), 32'd1);
        checkOutput($sformatf("dut%0d done dropped", inst), 32'(done_of(inst)), 32'd0);
      end
      setStart(inst, cycles == poke_at);
    end while (!done_of(inst) && cycles < 1000);
    checkOutput($sformatf("dut%0d latency", inst), 32'(cycles), 32'(3 + 4 * eff));
    checkOutput($sformatf("dut%0d error", inst), 32'(err_of(inst)), 32'(exp_err));
    checkOutput($sformatf("dut%0d busy at done", inst), 32'(busy_of(inst)), 32'd0);
    checkOutput($sformatf("dut%0d reads outstanding", inst),
                32'((inst == 0) ? aq0.size() : aq1.size()), 32'd0);
    checkLookups(inst);
  endtask

  initial begin
    int   eff;
    logic ee;
    rst_n  = 1'b0;
    start0 = 1'b0;
    start1 = 1'b0;
    label0 = 8'd0;
    label1 = 8'd0;
    for (int i = 0; i < 256; i++) begin
      mem0[i] = 8'h00;
      mem1[i] = 8'h00;
      tbl[i]  = 16'h0000;
    end

    // Reset state
    #12;
    checkOutput("reset busy", 32'(busy0), 32'd0);
    checkOutput("reset done", 32'(done0), 32'd0);
    checkOutput("reset error", 32'(err0), 32'd0);
    checkOutput("reset rd_en", 32'(rd_en0), 32'd0);
    checkOutput("reset addr dut0", 32'(addr0), 32'h00);
    checkOutput("reset addr dut1", 32'(addr1), 32'hFC);
    checkOutput("reset next_pc", 32'(pc0), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Three-entry table
    $display("[TB] three-entry load");
    tbl[0] = 16'h0002; tbl[1] = 16'h0160; tbl[2] = 16'h00CD;
    applyStimulus(0, 3, eff, ee);
    waitDone(0, eff, ee, -1);

    // Empty table: no entry reads, every lookup zero
    $display("[TB] empty table");
    applyStimulus(0, 0, eff, ee);
    waitDone(0, eff, ee, -1);

    // Oversized header clamps to capacity and flags a fault
    $display("[TB] oversized header");
    for (int i = 0; i < NL; i++) tbl[i] = {4'h0, 12'($urandom)};
    applyStimulus(0, 200, eff, ee);
    waitDone(0, eff, ee, -1);

    // Hi byte with excess bits: entry still written, fault raised, then cleared
    $display("[TB] hi-byte overflow");
    tbl[0] = 16'hF123; tbl[1] = 16'h0456;
    applyStimulus(0, 2, eff, ee);
    waitDone(0, eff, ee, -1);
    tbl[0] = 16'h0123;
    applyStimulus(0, 2, eff, ee);
    waitDone(0, eff, ee, -1);

    // Reset in the middle of a ten-entry load, then reload
    $display("[TB] reset mid-load");
    for (int i = 0; i < 10; i++) tbl[i] = {4'h0, 12'(16'h0A0 + i * 17)};
    applyStimulus(0, 10, eff, ee);
    @(posedge clk);
    #1;
    start0 = 1'b0;
    repeat (23) @(posedge clk);
    #1;
    label0 = 8'd2;
    #1;
    checkOutput("mid-load busy", 32'(busy0), 32'd1);
    checkOutput("mid-load label 2", 32'(pc0), 32'(tbl[2][11:0]));
    rst_n = 1'b0;
    #1;
    checkOutput("abort busy", 32'(busy0), 32'd0);
    checkOutput("abort done", 32'(done0), 32'd0);
    checkOutput("abort label 2", 32'(pc0), 32'd0);
    aq0.delete();
    lq0.delete();
    @(negedge clk);
    rst_n = 1'b1;
    applyStimulus(0, 10, eff, ee);
    waitDone(0, eff, ee, -1);

    // Wrapping addresses from base 0xFC; a start pulse while busy is ignored
    $display("[TB] wrapping base with start during busy");
    tbl[0] = 16'h0ABC; tbl[1] = 16'h0321;
    applyStimulus(1, 2, eff, ee);
    waitDone(1, eff, ee, 4);

    repeat (3) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", num_errors, num_checks);
    $finish;
  end

endmodule
